// File: rtl/flag_cdc_scheduler.sv
// Merges per-requester event flags onto one flag-crossing channel: round-robin
// grants, one-cycle pulses, and a guaranteed low gap so the far-side synchronizer sees every flag.
module flag_cdc_scheduler #(
    parameter int NREQ  = 4,
    parameter int GAP   = 6,
    parameter int CNT_W = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [NREQ-1:0] req_flag,
    input  logic [NREQ-1:0] ovf_clr,
    output logic            flag_out,
    output logic [ID_W-1:0] flag_id,
    output logic [NREQ-1:0] pending,
    output logic [NREQ-1:0] overflow,
    output logic            busy
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t           state, stateNext;
    logic [GAP_W-1:0] gapCnt;
    logic [ID_W-1:0]  rrPtr, grantIdx, searchIdx;
    logic [CNT_W-1:0] cnt [NREQ];
    logic [NREQ-1:0]  grantVec, incOnly, decOnly;
    logic             anyPend, grantFound, doGrant;

    always_comb begin
        pending = '0;
        for (int i = 0; i < NREQ; i++) pending[i] = (cnt[i] != '0);
    end

    assign anyPend = |pending;
    assign busy    = (state != IDLE) || anyPend;

    // Round-robin: first pending requester strictly after the last one served.
    always_comb begin
        grantIdx   = '0;
        grantFound = 1'b0;
        searchIdx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            searchIdx = ID_W'((int'(rrPtr) + k) % NREQ);
            if (!grantFound && pending[searchIdx]) begin
                grantFound = 1'b1;
                grantIdx   = searchIdx;
            end
        end
    end

    always_comb begin
        stateNext = state;
        doGrant   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && anyPend) begin
                    doGrant   = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: stateNext = HOLD;
            HOLD: begin
                if (gapCnt == '0) begin
                    if (enable && anyPend) begin
                        doGrant   = 1'b1;
                        stateNext = ISSUE;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        grantVec = '0;
        if (doGrant) grantVec[grantIdx] = 1'b1;
    end

    // A request and a grant on the same requester cancel out.
    assign incOnly = req_flag & ~grantVec;
    assign decOnly = grantVec & ~req_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gapCnt   <= '0;
            rrPtr    <= ID_W'(NREQ - 1);
            flag_out <= 1'b0;
            flag_id  <= '0;
        end else begin
            state    <= stateNext;
            flag_out <= doGrant;
            if (doGrant) begin
                flag_id <= grantIdx;
                rrPtr   <= grantIdx;
            end
            if (state == ISSUE)
                gapCnt <= GAP_LOAD;
            else if (state == HOLD && gapCnt != '0)
                gapCnt <= gapCnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                // A lost event sets the sticky bit even if a clear arrives at the same edge.
                if (incOnly[i] && cnt[i] == CNT_MAX)
                    overflow[i] <= 1'b1;
                else if (ovf_clr[i])
                    overflow[i] <= 1'b0;

                if (incOnly[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (decOnly[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end
endmodule

// File: doc/flag_cdc_scheduler.md
Name: flag_cdc_scheduler

Overview:
- Source-domain scheduler that merges NREQ independent one-cycle event flags onto a single shared flag-crossing channel.
- Counts pending events per requester and grants them round-robin.
- Emits one flag pulse plus its requester ID, and enforces a minimum low gap between pulses so the downstream toggle synchronizer never merges or drops flags.

Parameters:
- NREQ, 4, number of requesters (2..16).
- GAP, 6, low cycles forced after each issued flag (>=1); set to cover 3 destination-clock periods.
- CNT_W, 4, width of each per-requester pending counter; saturates at 2^CNT_W-1.
- ID_W, 2, width of flag_id; must satisfy 2^ID_W >= NREQ.

Ports:
- clk  in  1  single source clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, no new grants; pending counts keep accumulating.
- req_flag  in  NREQ  one-cycle event flags, one bit per requester.
- ovf_clr  in  NREQ  per-requester clear of the sticky overflow bit.
- flag_out  out  1  one-cycle flag to the crossing channel.
- flag_id  out  ID_W  index of the requester served; valid while flag_out=1.
- pending  out  NREQ  bit i = (count[i] != 0).
- overflow  out  NREQ  sticky; set when requester i loses an event to saturation.
- busy  out  1  1 whenever FSM is not IDLE or any count is nonzero.

Behaviour:
- Reset values:
  - flag_out=0, flag_id=0, overflow=0, every count=0.
  - FSM=IDLE, gap counter=0.
  - RR pointer=NREQ-1, so the first search starts at index 0.
- Counters:
  - req_flag[i]=1 increments count[i] at the same edge.
  - A grant to i decrements count[i].
  - Request and grant to the same i at the same edge: count unchanged.
  - Request at max count with no grant: count holds and overflow[i] sets at that edge.
  - ovf_clr[i] clears overflow[i]. If clear and a new overflow occur at the same edge, the set wins.
- Arbitration:
  - Round-robin over i with count[i]!=0.
  - Search order is ptr+1, ptr+2, … modulo NREQ.
  - On grant, ptr takes the granted index.
- FSM states:
  - IDLE: at an edge with enable=1 and any count!=0, grant and go to ISSUE. flag_out=1 and flag_id=grant are registered at that edge. Otherwise stay in IDLE.
  - ISSUE: flag_out is high for exactly this one cycle. Next edge: flag_out=0, gap counter loads GAP-1, go to HOLD.
  - HOLD: counter decrements each edge. At the edge where the counter is 0:
    - enable=1 and any pending: grant and go to ISSUE (back-to-back).
    - otherwise: go to IDLE.
- Timing:
  - Latency: req_flag sampled at edge k in IDLE gives flag_out high during the cycle after edge k+1. This is 2 cycles end to end.
  - Under continuous pending the flag period is exactly GAP+1 cycles (1 high, GAP low).
  - flag_out is never high in two consecutive cycles. Two flags are never closer than GAP low cycles.
- enable:
  - Deasserting enable never truncates an ISSUE or a HOLD.
  - Counting continues while enable=0.
- flag_id holds its last value when flag_out=0.
- Reset mid-operation: all state clears asynchronously and pending events are discarded. No flag is emitted on reset release until a new req_flag arrives.

Test Plan:
- Single event: NREQ=4, GAP=6, req_flag=4'b0100 at edge 10 -> flag_out=1, flag_id=2 in the cycle after edge 11. busy drops to 0 after edge 18 (end of the gap).
- Simultaneous burst: req_flag=4'b1111 for one cycle -> flags with flag_id 0,1,2,3 in order, each high 1 cycle, period 7 cycles. count returns to 0 and pending=0 after the 4th grant.
- Fairness plus bookkeeping:
  - Setup: requester 1 pulses every cycle for 40 cycles while requester 3 pulses once.
  - Required: flag_id alternates between 1 and 3 while both are pending.
  - Required: at-edge request+grant on requester 1 leaves count[1] unchanged.
- Saturation: CNT_W=4, requester 0 pulses 20 consecutive cycles with enable=0 -> count[0]=15, overflow[0]=1.
- Overflow clear and recovery:
  - Continue the saturation case by pulsing ovf_clr[0] -> overflow[0]=0.
  - Then set enable=1 -> exactly 15 flags with id 0 are emitted.
- Reset in HOLD: assert rst asynchronously mid-gap with count[2]=3 -> all outputs 0 immediately. After release with no requests, flag_out stays 0 for 50 cycles.
